lane_serializer: RTL and testbench

//  Downstream stage of the per-lane logic_l1 array: takes one full-width data word
//  and emits it as PAR_LANE_BITS-wide beats, lane 0 (LSBs) first.

---
 rtl/lane_serializer.sv | 115 +++++++++++
 tb/tb_lane_serializer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/lane_serializer.sv
// lane_serializer: splits a PAR_DATA_BITS word into PAR_LANE_BITS beats, lane 0 first.
// Optional even parity output ob_par with `define LANE_SERIALIZER_PARITY_EN.
module lane_serializer #(
    parameter int PAR_DATA_BITS = 64,
    parameter int PAR_LANE_BITS = 16,
    localparam int N = PAR_DATA_BITS / PAR_LANE_BITS,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic                     ib_clk,
    input  logic                     ib_rst_n,
    input  logic                     ib_flush,
    input  logic                     ib_valid,
    output logic                     ob_ready,
    input  logic [PAR_DATA_BITS-1:0] ivG_data,
    output logic                     ob_valid,
    input  logic                     ib_ready,
    output logic [PAR_LANE_BITS-1:0] ovG_lane,
    output logic [IW-1:0]            ovG_idx,
    output logic                     ob_last
`ifdef LANE_SERIALIZER_PARITY_EN
    ,output logic                    ob_par
`endif
);

    if ((PAR_DATA_BITS % PAR_LANE_BITS) != 0 || N < 2) begin : g_bad_cfg
        $error("lane_serializer: PAR_DATA_BITS must be a multiple (>=2) of PAR_LANE_BITS");
    end

    typedef enum logic {S_IDLE, S_SEND} state_e;

    state_e                   state_q, state_d;
    logic [PAR_DATA_BITS-1:0] act_q, act_d, pend_q, pend_d;
    logic                     pend_full_q, pend_full_d;
    logic [IW-1:0]            idx_q, idx_d;
    logic [PAR_LANE_BITS-1:0] lane_q, lane_d;
    logic                     last_q, last_d;
    logic                     rdy_en_q;
    logic                     fire_in, beat, act_free;

    // ready is held off until the first edge after reset release
    assign ob_ready = rdy_en_q & ~pend_full_q & ~ib_flush;
    assign fire_in  = ib_valid & ob_ready;
    assign ob_valid = (state_q == S_SEND);
    assign beat     = ob_valid & ib_ready;
    assign act_free = ~ob_valid | (beat & (idx_q == IW'(N - 1)));
    assign ovG_lane = lane_q;
    assign ovG_idx  = idx_q;
    assign ob_last  = last_q;

    always_comb begin
        state_d     = state_q;
        act_d       = act_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        idx_d       = idx_q;
        if (ib_flush) begin
            state_d     = S_IDLE;
            pend_full_d = 1'b0;
            idx_d       = '0;
        end else if (act_free) begin
            idx_d = '0;
            if (pend_full_q) begin
                act_d       = pend_q;
                pend_full_d = 1'b0;
                state_d     = S_SEND;
            end else if (fire_in) begin
                act_d   = ivG_data;
                state_d = S_SEND;
            end else begin
                state_d = S_IDLE;
            end
        end else begin
            if (beat) idx_d = idx_q + 1'b1;
            if (fire_in) begin
                pend_d      = ivG_data;
                pend_full_d = 1'b1;
            end
        end
        // beat outputs are registered from the next-state word and index
        lane_d = (state_d == S_SEND) ? act_d[idx_d*PAR_LANE_BITS +: PAR_LANE_BITS] : '0;
        last_d = (state_d == S_SEND) && (idx_d == IW'(N - 1));
    end

    always_ff @(posedge ib_clk or negedge ib_rst_n) begin
        if (!ib_rst_n) begin
            state_q     <= S_IDLE;
            act_q       <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            idx_q       <= '0;
            lane_q      <= '0;
            last_q      <= 1'b0;
            rdy_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            act_q       <= act_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            idx_q       <= idx_d;
            lane_q      <= lane_d;
            last_q      <= last_d;
            rdy_en_q    <= 1'b1;
        end
    end

`ifdef LANE_SERIALIZER_PARITY_EN
    logic par_q;
    always_ff @(posedge ib_clk or negedge ib_rst_n) begin
        if (!ib_rst_n) par_q <= 1'b0;
        else           par_q <= ^lane_d;
    end
    assign ob_par = par_q;
`endif

endmodule

// File: tb/tb_lane_serializer.sv
// tb_lane_serializer: vector tables, corner sequences and random traffic against a beat-queue model.
module tb_lane_serializer;
    localparam int DW = 64;
    localparam int LW = 16;
    localparam int N  = DW / LW;

    logic          ib_clk = 1'b0;
    logic          ib_rst_n, ib_flush, ib_valid, ob_ready, ob_valid, ib_ready, ob_last;
    logic [DW-1:0] ivG_data;
    logic [LW-1:0] ovG_lane;
    logic [1:0]    ovG_idx;
`ifdef LANE_SERIALIZER_PARITY_EN
    logic          ob_par;
`endif

    lane_serializer #(.PAR_DATA_BITS(DW), .PAR_LANE_BITS(LW)) dut (
        .ib_clk(ib_clk), .ib_rst_n(ib_rst_n), .ib_flush(ib_flush), .ib_valid(ib_valid),
        .ob_ready(ob_ready), .ivG_data(ivG_data), .ob_valid(ob_valid), .ib_ready(ib_ready),
        .ovG_lane(ovG_lane), .ovG_idx(ovG_idx), .ob_last(ob_last)
`ifdef LANE_SERIALIZER_PARITY_EN
        , .ob_par(ob_par)
`endif
    );

    always #5 ib_clk = ~ib_clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [LW-1:0] lane;
        int            idx;
    } beat_t;
    beat_t bq[$];
    bit    rdy_en = 1'b0;
    logic  m_ready;

    typedef struct {
        logic          v;
        logic [DW-1:0] d;
        logic          ev;
        logic [LW-1:0] el;
        int            ei;
        logic          elast;
        logic          erdy;
    } vec_t;
    vec_t tv[16];

    localparam logic [DW-1:0] W1 = 64'h4444_3333_2222_1111;
    localparam logic [DW-1:0] W2 = 64'h8888_7777_6666_5555;
    localparam logic [DW-1:0] W3 = 64'hCCCC_BBBB_AAAA_9999;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // Expected outputs come from the queue of beats still owed downstream.
    task automatic model_check();
        m_ready = rdy_en && (((bq.size() + N - 1) / N) < 2) && !ib_flush;
        chk("ob_ready", 64'(ob_ready), 64'(m_ready));
        chk("ob_valid", 64'(ob_valid), 64'(bq.size() > 0));
        if (bq.size() > 0) begin
            chk("ovG_lane", 64'(ovG_lane), 64'(bq[0].lane));
            chk("ovG_idx", 64'(ovG_idx), 64'(bq[0].idx));
            chk("ob_last", 64'(ob_last), 64'(bq[0].idx == N - 1));
`ifdef LANE_SERIALIZER_PARITY_EN
            chk("ob_par", 64'(ob_par), 64'(^bq[0].lane));
`endif
        end else begin
            chk("ob_last_idle", 64'(ob_last), 64'(0));
        end
    endtask

    task automatic model_step(input logic v, input logic r, input logic f, input logic [DW-1:0] d);
        if (f) begin
            bq.delete();
        end else begin
            if (bq.size() > 0 && r) void'(bq.pop_front());
            if (v && m_ready)
                for (int i = 0; i < N; i++) bq.push_back('{d[i*LW +: LW], i});
        end
        rdy_en = 1'b1;
    endtask

    task automatic drive(input logic v, input logic r, input logic f, input logic [DW-1:0] d);
        ib_valid = v;
        ib_ready = r;
        ib_flush = f;
        ivG_data = d;
        #2;
        model_check();
    endtask

    task automatic tick();
        @(posedge ib_clk);
        model_step(ib_valid, ib_ready, ib_flush, ivG_data);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b1, 1'b0, '0);
            tick();
        end
    endtask

    initial begin
        // single word, then two words back-to-back with ib_valid held high
        tv[0]  = '{1'b1, W1, 1'b0, 16'h0000, 0, 1'b0, 1'b1};
        tv[1]  = '{1'b0, '0, 1'b1, 16'h1111, 0, 1'b0, 1'b1};
        tv[2]  = '{1'b0, '0, 1'b1, 16'h2222, 1, 1'b0, 1'b1};
        tv[3]  = '{1'b0, '0, 1'b1, 16'h3333, 2, 1'b0, 1'b1};
        tv[4]  = '{1'b0, '0, 1'b1, 16'h4444, 3, 1'b1, 1'b1};
        tv[5]  = '{1'b1, W2, 1'b0, 16'h0000, 0, 1'b0, 1'b1};
        tv[6]  = '{1'b1, W3, 1'b1, 16'h5555, 0, 1'b0, 1'b1};
        tv[7]  = '{1'b1, W3, 1'b1, 16'h6666, 1, 1'b0, 1'b0};
        tv[8]  = '{1'b1, W3, 1'b1, 16'h7777, 2, 1'b0, 1'b0};
        tv[9]  = '{1'b1, W3, 1'b1, 16'h8888, 3, 1'b1, 1'b0};
        tv[10] = '{1'b0, '0, 1'b1, 16'h9999, 0, 1'b0, 1'b1};
        tv[11] = '{1'b0, '0, 1'b1, 16'hAAAA, 1, 1'b0, 1'b1};
        tv[12] = '{1'b0, '0, 1'b1, 16'hBBBB, 2, 1'b0, 1'b1};
        tv[13] = '{1'b0, '0, 1'b1, 16'hCCCC, 3, 1'b1, 1'b1};
        tv[14] = '{1'b0, '0, 1'b0, 16'h0000, 0, 1'b0, 1'b1};
        tv[15] = '{1'b0, '0, 1'b0, 16'h0000, 0, 1'b0, 1'b1};

        ib_rst_n = 1'b0;
        ib_flush = 1'b0;
        ib_valid = 1'b0;
        ib_ready = 1'b1;
        ivG_data = '0;
        repeat (3) @(posedge ib_clk);
        #1;
        chk("rst_valid", 64'(ob_valid), 64'(0));
        chk("rst_lane", 64'(ovG_lane), 64'(0));
        chk("rst_idx", 64'(ovG_idx), 64'(0));
        chk("rst_last", 64'(ob_last), 64'(0));
        ib_rst_n = 1'b1;
        idle(1);

        for (int i = 0; i < 16; i++) begin
            drive(tv[i].v, 1'b1, 1'b0, tv[i].d);
            chk($sformatf("tbl%0d_valid", i), 64'(ob_valid), 64'(tv[i].ev));
            chk($sformatf("tbl%0d_ready", i), 64'(ob_ready), 64'(tv[i].erdy));
            chk($sformatf("tbl%0d_last", i), 64'(ob_last), 64'(tv[i].elast));
            if (tv[i].ev) begin
                chk($sformatf("tbl%0d_lane", i), 64'(ovG_lane), 64'(tv[i].el));
                chk($sformatf("tbl%0d_idx", i), 64'(ovG_idx), 64'(tv[i].ei));
            end
            tick();
        end

        // stall three cycles on beat idx 1
        drive(1'b1, 1'b1, 1'b0, W1); tick();
        drive(1'b0, 1'b1, 1'b0, '0); tick();
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, 1'b0, '0);
            chk("stall_lane", 64'(ovG_lane), 64'h2222);
            chk("stall_idx", 64'(ovG_idx), 64'(1));
            chk("stall_valid", 64'(ob_valid), 64'(1));
            tick();
        end
        drive(1'b0, 1'b1, 1'b0, '0);
        chk("resume_idx", 64'(ovG_idx), 64'(1));
        tick();
        drive(1'b0, 1'b1, 1'b0, '0);
        chk("resume_lane", 64'(ovG_lane), 64'h3333);
        tick();
        idle(2);

        // flush at idx 2 with pending occupied; offered input must be dropped
        drive(1'b1, 1'b1, 1'b0, W1); tick();
        drive(1'b1, 1'b1, 1'b0, W2); tick();
        drive(1'b0, 1'b1, 1'b0, '0); tick();
        drive(1'b1, 1'b1, 1'b1, W3);
        chk("flush_idx", 64'(ovG_idx), 64'(2));
        chk("flush_ready", 64'(ob_ready), 64'(0));
        tick();
        drive(1'b0, 1'b1, 1'b0, '0);
        chk("post_flush_valid", 64'(ob_valid), 64'(0));
        chk("post_flush_ready", 64'(ob_ready), 64'(1));
        tick();
        drive(1'b1, 1'b1, 1'b0, W3); tick();
        drive(1'b0, 1'b1, 1'b0, '0);
        chk("after_flush_idx", 64'(ovG_idx), 64'(0));
        chk("after_flush_lane", 64'(ovG_lane), 64'h9999);
        tick();
        idle(4);

        // asynchronous reset in the middle of a word
        drive(1'b1, 1'b1, 1'b0, W2); tick();
        drive(1'b0, 1'b1, 1'b0, '0); tick();
        chk("pre_rst_idx", 64'(ovG_idx), 64'(1));
        #2;
        ib_rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(ob_valid), 64'(0));
        chk("async_rst_idx", 64'(ovG_idx), 64'(0));
        chk("async_rst_lane", 64'(ovG_lane), 64'(0));
        bq.delete();
        rdy_en = 1'b0;
        @(posedge ib_clk);
        #1;
        ib_rst_n = 1'b1;
        idle(1);
        drive(1'b1, 1'b1, 1'b0, W3);
        chk("post_rst_ready", 64'(ob_ready), 64'(1));
        tick();
        drive(1'b0, 1'b1, 1'b0, '0);
        chk("post_rst_idx", 64'(ovG_idx), 64'(0));
        chk("post_rst_lane", 64'(ovG_lane), 64'h9999);
        tick();
        idle(4);

`ifdef LANE_SERIALIZER_PARITY_EN
        drive(1'b1, 1'b1, 1'b0, 64'h0000_0000_0003_0001); tick();
        drive(1'b0, 1'b1, 1'b0, '0);
        chk("par_0001", 64'(ob_par), 64'(1));
        tick();
        drive(1'b0, 1'b1, 1'b0, '0);
        chk("par_0003", 64'(ob_par), 64'(0));
        tick();
        idle(3);
`endif

        for (int c = 0; c < 3000; c++) begin
            drive(1'b1 & (($urandom % 4) != 0), 1'b1 & (($urandom % 4) != 0),
                  1'b1 & (($urandom % 64) == 0), {$urandom, $urandom});
            tick();
        end
        idle(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
